cpuc_dual_ram_bank: RTL and testbench



---
 rtl/cpuc_dual_ram_bank.sv | 158 +++++++++++++++
 tb/tb_cpuc_dual_ram_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpuc_dual_ram_bank.sv
// True dual-port RAM bank: request handshake, byte-enable writes, registered reads, init sweep.
// Optional collision detector (coll_err/coll_cnt) enabled by defining CPUC_DUAL_RAM_COLL_DET_EN.
module cpuc_dual_ram_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    MEM_SIZE   = 1024,
  parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  init_done,
`ifdef CPUC_DUAL_RAM_COLL_DET_EN
  output logic                  coll_err,
  output logic [15:0]           coll_cnt,
`endif
  input  logic                  req_a,
  input  logic                  wren_a,
  input  logic [BE_WIDTH-1:0]   be_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  q_valid_a,
  input  logic                  req_b,
  input  logic                  wren_b,
  input  logic [BE_WIDTH-1:0]   be_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  q_valid_b
);

  localparam int                  IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(MEM_SIZE - 1);
  localparam logic [IDX_W-1:0]    ONE_IDX    = IDX_W'(1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  state_e                state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  init_done_q;
  logic [DATA_WIDTH-1:0] q_a_q, q_b_q;
  logic                  q_valid_a_q, q_valid_b_q;

  logic             acc_a_s, acc_b_s;
  logic             in_rng_a_s, in_rng_b_s;
  logic             wr_a_s, wr_b_s, rd_a_s, rd_b_s;
  logic [IDX_W-1:0] idx_a_s, idx_b_s;

  // init_done and the READY state move together, so it doubles as the accept gate
  assign acc_a_s    = req_a & init_done_q;
  assign acc_b_s    = req_b & init_done_q;
  assign in_rng_a_s = ({1'b0, address_a} < MEM_SIZE_W);
  assign in_rng_b_s = ({1'b0, address_b} < MEM_SIZE_W);
  assign idx_a_s    = address_a[IDX_W-1:0];
  assign idx_b_s    = address_b[IDX_W-1:0];
  assign wr_a_s     = acc_a_s & wren_a & in_rng_a_s;
  assign wr_b_s     = acc_b_s & wren_b & in_rng_b_s;
  assign rd_a_s     = acc_a_s & ~wren_a;
  assign rd_b_s     = acc_b_s & ~wren_b;

  // Control FSM: sweep counter and init_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST_IDX) begin
            state_q     <= ST_READY;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE_IDX;
          end
        end
        ST_READY: begin
          if (clr_req) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_INIT;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage writes; B is issued after A so B wins any byte both ports enable
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_a_s && be_a[i]) mem[idx_a_s][8*i +: 8] <= data_a[8*i +: 8];
        if (wr_b_s && be_b[i]) mem[idx_b_s][8*i +: 8] <= data_b[8*i +: 8];
      end
    end
  end

  // Registered read ports (read-first against same-cycle writes)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q       <= '0;
      q_b_q       <= '0;
      q_valid_a_q <= 1'b0;
      q_valid_b_q <= 1'b0;
    end else begin
      q_valid_a_q <= rd_a_s;
      q_valid_b_q <= rd_b_s;
      if (rd_a_s) q_a_q <= in_rng_a_s ? mem[idx_a_s] : INIT_VALUE;
      if (rd_b_s) q_b_q <= in_rng_b_s ? mem[idx_b_s] : INIT_VALUE;
    end
  end

  assign init_done = init_done_q;
  assign q_a       = q_a_q;
  assign q_b       = q_b_q;
  assign q_valid_a = q_valid_a_q;
  assign q_valid_b = q_valid_b_q;

`ifdef CPUC_DUAL_RAM_COLL_DET_EN
  logic        coll_s;
  logic        coll_err_q;
  logic [15:0] coll_cnt_q;

  assign coll_s = acc_a_s & acc_b_s & (address_a == address_b) & (wren_a | wren_b);

  // Collision pulse and saturating event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_err_q <= 1'b0;
      coll_cnt_q <= 16'd0;
    end else begin
      coll_err_q <= coll_s;
      if (init_done_q && clr_req) begin
        coll_cnt_q <= 16'd0;
      end else if (coll_s && (coll_cnt_q != 16'hFFFF)) begin
        coll_cnt_q <= coll_cnt_q + 16'd1;
      end
    end
  end

  assign coll_err = coll_err_q;
  assign coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_cpuc_dual_ram_bank.sv
// Directed self-checking bench for cpuc_dual_ram_bank (MEM_SIZE=16, ADDR_WIDTH=5).
module tb_cpuc_dual_ram_bank;

  localparam int          DW = 32;
  localparam int          AW = 5;
  localparam int          MS = 16;
  localparam logic [31:0] IV = 32'hC0DE_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req;
  logic          init_done;
  logic          req_a, wren_a, req_b, wren_b;
  logic [3:0]    be_a, be_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] data_a, data_b, q_a, q_b;
  logic          q_valid_a, q_valid_b;
`ifdef CPUC_DUAL_RAM_COLL_DET_EN
  logic          coll_err;
  logic [15:0]   coll_cnt;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  cpuc_dual_ram_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_done(init_done),
`ifdef CPUC_DUAL_RAM_COLL_DET_EN
    .coll_err(coll_err), .coll_cnt(coll_cnt),
`endif
    .req_a(req_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
    .data_a(data_a), .q_a(q_a), .q_valid_a(q_valid_a),
    .req_b(req_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
    .data_b(data_b), .q_b(q_b), .q_valid_b(q_valid_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 1'b0; wren_a = 1'b0; be_a = 4'h0; address_a = 5'd0; data_a = 32'h0;
    req_b = 1'b0; wren_b = 1'b0; be_b = 4'h0; address_b = 5'd0; data_b = 32'h0;
    clr_req = 1'b0;
  endtask

  task automatic op_a(input logic wr, input logic [3:0] be, input logic [AW-1:0] ad, input logic [31:0] d);
    req_a = 1'b1; wren_a = wr; be_a = be; address_a = ad; data_a = d;
  endtask

  task automatic op_b(input logic wr, input logic [3:0] be, input logic [AW-1:0] ad, input logic [31:0] d);
    req_b = 1'b1; wren_b = wr; be_b = be; address_b = ad; data_b = d;
  endtask

  // Called at #1 after the edge that starts a sweep (or after reset release)
  task automatic wait_sweep(input string tag);
    for (int i = 1; i < MS; i++) begin
      cyc();
      chk1({tag, "_busy"}, init_done, 1'b0);
      chk1({tag, "_noval"}, q_valid_b, 1'b0);
    end
    idle();
    cyc();
    chk1({tag, "_done"}, init_done, 1'b1);
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_qv_a", q_valid_a, 1'b0);
    chk("rst_q_a", q_a, 32'h0);
    chk("rst_q_b", q_b, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    // requests during the sweep must be ignored
    op_a(1'b1, 4'hF, 5'd0, 32'hFFFF_FFFF);
    op_b(1'b0, 4'h0, 5'd0, 32'h0);
    wait_sweep("sweep0");

    for (int a = 0; a < MS; a++) begin
      op_a(1'b0, 4'h0, 5'(a), 32'h0);
      cyc();
      chk1("init_rd_valid", q_valid_a, 1'b1);
      chk($sformatf("init_rd_%0d", a), q_a, IV);
    end
    idle();
    cyc();
    chk1("strobe_drop", q_valid_a, 1'b0);
    chk("q_a_hold", q_a, IV);

    op_b(1'b0, 4'h0, 5'd20, 32'h0);
    cyc();
    chk1("oor_rd_valid", q_valid_b, 1'b1);
    chk("oor_rd_data", q_b, IV);
    idle();

    // byte-enable merge
    op_a(1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF);
    cyc();
    op_a(1'b1, 4'h1, 5'd5, 32'h0000_00AA);
    cyc();
    idle();
    op_b(1'b0, 4'h0, 5'd5, 32'h0);
    cyc();
    chk1("be_rd_valid", q_valid_b, 1'b1);
    chk("be_merge", q_b, 32'hDEAD_BEAA);
    idle();
    cyc();
    chk1("be_strobe_drop", q_valid_b, 1'b0);
    chk("be_q_b_hold", q_b, 32'hDEAD_BEAA);

    // write/write collision, B wins the low bytes
    op_a(1'b1, 4'hF, 5'd3, 32'h1111_1111);
    op_b(1'b1, 4'h3, 5'd3, 32'h2222_2222);
    cyc();
`ifdef CPUC_DUAL_RAM_COLL_DET_EN
    chk1("coll_ww_pulse", coll_err, 1'b1);
`endif
    idle();
    op_a(1'b0, 4'h0, 5'd3, 32'h0);
    cyc();
    chk("ww_collision", q_a, 32'h1111_2222);
    idle();

    // read-during-write returns old data
    op_a(1'b1, 4'hF, 5'd7, 32'h0000_0055);
    op_b(1'b0, 4'h0, 5'd7, 32'h0);
    cyc();
    chk("rdw_old", q_b, IV);
    chk1("rdw_valid_b", q_valid_b, 1'b1);
    chk1("rdw_no_valid_a", q_valid_a, 1'b0);
    idle();
    op_a(1'b0, 4'h0, 5'd7, 32'h0);
    cyc();
    chk("rdw_new", q_a, 32'h0000_0055);
    idle();

    // be=0 no-op and out-of-range write (would alias onto addr 5)
    op_a(1'b1, 4'h0, 5'd5, 32'h0);
    op_b(1'b1, 4'hF, 5'd21, 32'hFFFF_FFFF);
    cyc();
    idle();
    op_a(1'b0, 4'h0, 5'd5, 32'h0);
    op_b(1'b0, 4'h0, 5'd21, 32'h0);
    cyc();
    chk("be0_noop", q_a, 32'hDEAD_BEAA);
    chk("oor_wr_dropped", q_b, IV);
    idle();

`ifdef CPUC_DUAL_RAM_COLL_DET_EN
    cyc();
    chk("coll_cnt_pre", {16'd0, coll_cnt}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      op_a(1'b1, 4'hF, 5'd2, 32'(k));
      op_b(1'b1, 4'hF, 5'd2, 32'(k + 8));
      cyc();
      chk1("coll_pulse", coll_err, 1'b1);
      idle();
      cyc();
      chk1("coll_pulse_end", coll_err, 1'b0);
    end
    op_a(1'b0, 4'h0, 5'd2, 32'h0);
    op_b(1'b0, 4'h0, 5'd2, 32'h0);
    cyc();
    chk1("coll_rr_none", coll_err, 1'b0);
    chk("coll_cnt_post", {16'd0, coll_cnt}, 32'd5);
    idle();
`endif

    // clr_req restarts the sweep; same-cycle read is still served
    op_b(1'b0, 4'h0, 5'd7, 32'h0);
    clr_req = 1'b1;
    cyc();
    idle();
    chk1("clr_init_drop", init_done, 1'b0);
    chk1("clr_rd_valid", q_valid_b, 1'b1);
    chk("clr_rd_data", q_b, 32'h0000_0055);
    op_a(1'b1, 4'hF, 5'd10, 32'hFFFF_0000);
    op_b(1'b0, 4'h0, 5'd10, 32'h0);
    wait_sweep("sweep_clr");
`ifdef CPUC_DUAL_RAM_COLL_DET_EN
    chk("coll_cnt_clr", {16'd0, coll_cnt}, 32'd0);
`endif
    op_a(1'b0, 4'h0, 5'd10, 32'h0);
    op_b(1'b0, 4'h0, 5'd7, 32'h0);
    cyc();
    chk("clr_rd_10", q_a, IV);
    chk("clr_rd_7", q_b, IV);
    op_a(1'b0, 4'h0, 5'd5, 32'h0);
    op_b(1'b0, 4'h0, 5'd3, 32'h0);
    cyc();
    chk("clr_rd_5", q_a, IV);
    chk("clr_rd_3", q_b, IV);
    idle();

    // reset in the middle of a sweep
    op_a(1'b1, 4'hF, 5'd4, 32'h1234_5678);
    clr_req = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 4; i++) cyc();
    rst_n = 1'b0;
    #1;
    chk1("midrst_init_done", init_done, 1'b0);
    chk("midrst_q_a", q_a, 32'h0);
    chk("midrst_q_b", q_b, 32'h0);
    cyc();
    rst_n = 1'b1;
    wait_sweep("sweep_rst");
    op_a(1'b0, 4'h0, 5'd4, 32'h0);
    op_b(1'b0, 4'h0, 5'd15, 32'h0);
    cyc();
    chk("midrst_rd_4", q_a, IV);
    chk("midrst_rd_15", q_b, IV);
    idle();
    cyc();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
